// File: rtl/ffd_piso_tx.sv
`default_nettype none
// ============================================================================
// Module   : ffd_piso_tx
// Purpose  : Enable-gated PISO transmitter, valid/ready load, MSB-first, done pulse
// Revision : 1.0
// ============================================================================
module ffd_piso_tx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] D,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_SHIFT   = 2'b01,
        S_DONE    = 2'b10,
        S_ILLEGAL = 2'b11
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (en) begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (load_valid) begin
                    w_shreg_nxt = D;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_shreg_nxt = {r_shreg[WIDTH-2:0], 1'b0};
                if (r_cnt == C_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                // Unreachable encoding: recover to a clean idle frame boundary
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign load_ready = (r_state == S_IDLE);
    assign sout_valid = (r_state == S_SHIFT);
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign sout       = (r_state == S_SHIFT) ? r_shreg[WIDTH-1] : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_ffd_piso_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ffd_piso_tx
// Purpose  : Table-driven checks of ffd_piso_tx (WIDTH=4) plus async-reset sequences
// Revision : 1.0
// ============================================================================
module tb_ffd_piso_tx;

    localparam int WIDTH = 4;

    logic             clk;
    logic             reset;
    logic             en;
    logic [WIDTH-1:0] D;
    logic             load_valid;
    logic             load_ready;
    logic             sout;
    logic             sout_valid;
    logic             busy;
    logic             done;

    int n_checks;
    int n_fail;

    // Output vector order: {load_ready, sout, sout_valid, busy, done}
    typedef struct packed {
        logic             rst;
        logic             en;
        logic             lv;
        logic [WIDTH-1:0] d;
        logic [4:0]       exp;
    } vec_t;

    localparam logic [4:0] C_IDLE = 5'b10000;
    localparam logic [4:0] C_B1   = 5'b01110;
    localparam logic [4:0] C_B0   = 5'b00110;
    localparam logic [4:0] C_DONE = 5'b00011;

    vec_t vecs[$];

    ffd_piso_tx #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .D          (D),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [4:0] exp);
        logic [4:0] act;
        act = {load_ready, sout, sout_valid, busy, done};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {rdy,sout,sv,busy,done}=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic l,
                       input logic [WIDTH-1:0] d, input logic [4:0] x);
        vec_t v;
        v.rst = r; v.en = e; v.lv = l; v.d = d; v.exp = x;
        vecs.push_back(v);
    endtask

    task automatic step(input logic r, input logic e, input logic l,
                        input logic [WIDTH-1:0] d, input logic [4:0] x, input string name);
        reset = r; en = e; load_valid = l; D = d;
        @(posedge clk);
        #1;
        check(name, x);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        en         = 1'b1;
        load_valid = 1'b0;
        D          = '0;

        // 1: reset then idle
        add(1, 1, 0, 4'b0000, C_IDLE);
        add(1, 1, 0, 4'b0000, C_IDLE);
        for (int i = 0; i < 5; i++) add(0, 1, 0, 4'b0000, C_IDLE);

        // 2: basic frame 1011
        add(0, 1, 1, 4'b1011, C_B1);
        add(0, 1, 0, 4'b0000, C_B0);
        add(0, 1, 0, 4'b0000, C_B1);
        add(0, 1, 0, 4'b0000, C_B1);
        add(0, 1, 0, 4'b0000, C_DONE);
        add(0, 1, 0, 4'b0000, C_IDLE);

        // 3: enable stall on second bit of 0110
        add(0, 1, 1, 4'b0110, C_B0);
        add(0, 1, 0, 4'b0110, C_B1);
        add(0, 0, 0, 4'b0110, C_B1);
        add(0, 0, 0, 4'b0110, C_B1);
        add(0, 0, 0, 4'b0110, C_B1);
        add(0, 1, 0, 4'b0110, C_B1);
        add(0, 1, 0, 4'b0110, C_B0);
        add(0, 1, 0, 4'b0110, C_DONE);
        add(0, 1, 0, 4'b0110, C_IDLE);

        // 4: loads ignored while busy
        add(0, 1, 1, 4'b1001, C_B1);
        add(0, 1, 1, 4'b1111, C_B0);
        add(0, 1, 1, 4'b1111, C_B0);
        add(0, 1, 1, 4'b1111, C_B1);
        add(0, 1, 1, 4'b1111, C_DONE);
        add(0, 1, 1, 4'b1111, C_IDLE);
        add(0, 1, 1, 4'b1111, C_B1);
        add(0, 1, 0, 4'b0000, C_B1);
        add(0, 1, 0, 4'b0000, C_B1);
        add(0, 1, 0, 4'b0000, C_B1);
        add(0, 1, 0, 4'b0000, C_DONE);
        add(0, 1, 0, 4'b0000, C_IDLE);

        // 6: back-to-back frames with load_valid held high
        add(0, 1, 1, 4'b1100, C_B1);
        add(0, 1, 1, 4'b0011, C_B1);
        add(0, 1, 1, 4'b0011, C_B0);
        add(0, 1, 1, 4'b0011, C_B0);
        add(0, 1, 1, 4'b0011, C_DONE);
        add(0, 1, 1, 4'b0011, C_IDLE);
        add(0, 1, 1, 4'b0011, C_B0);
        add(0, 1, 0, 4'b0000, C_B0);
        add(0, 1, 0, 4'b0000, C_B1);
        add(0, 1, 0, 4'b0000, C_B1);
        add(0, 1, 0, 4'b0000, C_DONE);
        add(0, 1, 0, 4'b0000, C_IDLE);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].lv, vecs[i].d, vecs[i].exp,
                 $sformatf("vec%0d", i));
        end

        // 5: reset mid-frame acts with no clock edge, then a fresh frame
        step(0, 1, 1, 4'b1110, C_B1, "rst_f1_b3");
        step(0, 1, 0, 4'b0000, C_B1, "rst_f1_b2");
        reset = 1'b1;
        #1;
        check("rst_async", C_IDLE);
        step(1, 1, 0, 4'b0000, C_IDLE, "rst_hold");
        step(0, 1, 0, 4'b0000, C_IDLE, "rst_nodone");
        step(0, 1, 1, 4'b0101, C_B0, "fresh_b3");
        step(0, 1, 0, 4'b0000, C_B1, "fresh_b2");
        step(0, 1, 0, 4'b0000, C_B0, "fresh_b1");
        step(0, 1, 0, 4'b0000, C_B1, "fresh_b0");
        step(0, 1, 0, 4'b0000, C_DONE, "fresh_done");
        step(0, 1, 0, 4'b0000, C_IDLE, "fresh_idle");

        // Reset still acts while en=0
        step(0, 1, 1, 4'b1000, C_B1, "en0_load");
        en    = 1'b0;
        reset = 1'b1;
        #1;
        check("en0_rst_async", C_IDLE);
        step(0, 0, 0, 4'b0000, C_IDLE, "en0_rst_hold");
        step(0, 1, 0, 4'b0000, C_IDLE, "en0_rst_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
